pwm_gen_multi: RTL and testbench
================================

PWM_GEN_MULTI -- requirements
Module: pwm_gen_multi

Interface
REQ-001 Parameter: WIDTH, default 13, bit width of counter, period, offset and duty values.
REQ-002 Parameter: N_CH, default 3, number of PWM output channels.
REQ-003 Parameter: N_PULSE, default 2, number of pulse windows per channel (ORed together).
REQ-004 Port: clk_in  input  1  single system clock; all logic on rising edge.
REQ-005 Port: rst_in  input  1  reset, asynchronous, active-high.
REQ-006 Port: en  input  1  run enable; 0 = counter held, outputs low.
REQ-007 Port: period  input  WIDTH  frame length in clk_in cycles (staged value).
REQ-008 Port: offset_bus  input  N_CH*N_PULSE*WIDTH  window offsets; window k of channel c at bits [(c*N_PULSE+k)*WIDTH +: WIDTH].
REQ-009 Port: duty_bus  input  N_CH*N_PULSE*WIDTH  window durations, same packing as offset_bus.
REQ-010 Port: load_req  input  1  single-cycle request to stage period/offset_bus/duty_bus.
REQ-011 Port: load_ack  output  1  single-cycle pulse when staged set becomes active.
REQ-012 Port: pwm_out  output  N_CH  registered PWM outputs, bit c = channel c.
REQ-013 Port: frame_start  output  1  single-cycle pulse on the cycle counter value is 0 while running.
REQ-014 Port: cfg_err  output  1  high while active period < 2.

Function
REQ-015 Shared frame counter cnt (WIDTH bits) SHALL count 0..P-1 and wrap to 0, where P is the active period, when en=1 and P>=2.
REQ-016 When en=0 or P<2: cnt SHALL be held at 0, pwm_out SHALL be all 0, frame_start SHALL be 0.
REQ-017 Window (c,k) with active offset O, duty D SHALL be "on" when cnt in [O, O+D) computed in WIDTH+1 bits; if O+D > P, window SHALL also be on for cnt < O+D-P (wrap-around).
REQ-018 D=0 SHALL give window never on; D>=P SHALL give window always on; O>=P SHALL give window never on.
REQ-019 pwm_out[c] SHALL be the OR of its N_PULSE windows, registered: value at cycle t+1 reflects cnt at cycle t (latency 1).
REQ-020 frame_start SHALL be registered with the same 1-cycle alignment as pwm_out (asserts with the pwm_out sample for cnt=0).
REQ-021 On load_req=1, period/offset_bus/duty_bus SHALL be captured into staging registers and a pending flag set.
REQ-022 load_req while pending SHALL overwrite staging (last write wins); only one load_ack SHALL result.
REQ-023 Running (en=1, P>=2): pending staging SHALL copy to active registers on the wrap cycle (cnt=P-1 -> 0); load_ack SHALL pulse in the cycle after the wrap edge; pending cleared.
REQ-024 load_req coinciding with the wrap cycle SHALL be staged and applied at the following wrap, not the current one.
REQ-025 Not running (en=0 or P<2): pending staging SHALL apply on the next clock edge; load_ack pulses the cycle after.
REQ-026 A newly active period SHALL take effect from cnt=0; cnt SHALL never reach a value >= the active period.
REQ-027 en falling SHALL take effect next edge (cnt->0, outputs low); en rising SHALL start counting from cnt=0 with frame_start on the first output cycle.
REQ-028 cfg_err SHALL be combinational from active period (<2).

Reset
REQ-029 rst_in=1 SHALL immediately clear cnt, active and staging registers, pending flag, pwm_out, load_ack, frame_start to 0 (cfg_err=1 since active period=0).
REQ-030 Reset asserted mid-frame or with load pending SHALL discard the pending load; no load_ack after release.
REQ-031 After rst_in release, no output SHALL change until a load and en=1 occur.

Verification
REQ-032 Reset, load P=10, ch0 win0 O=2 D=3, en=1 -> pwm_out[0] high for cnt 2,3,4 (one cycle later), period 10 cycles, frame_start every 10 cycles.
REQ-033 P=10, O=8 D=4 -> on at cnt 8,9,0,1; D=0 -> always low; D=12 -> always high.
REQ-034 ch1 win0 O=1 D=2, win1 O=6 D=2 -> two pulses per frame (cnt 1-2, 6-7); verifies OR merge.
REQ-035 Running P=10, load_req at cnt=4 with P=6 -> old frame completes to cnt 9, load_ack once, next frame length 6; load_req exactly at cnt=9 -> applied one frame later.
REQ-036 Two load_req in one frame (second with D=5) -> single load_ack, D=5 active.
REQ-037 rst_in asserted at cnt=5 with load pending -> all outputs 0 asynchronously, cfg_err=1, no load_ack after release.

Source files
------------

// File: rtl/pwm_gen_multi.sv
// -----------------------------------------------------------------------------
// pwm_gen_multi
//
// Multi-channel PWM generator with one shared frame counter. Each channel
// owns N_PULSE programmable windows (offset + duration), and the channel
// output is the OR of its windows. Period, offsets and durations are written
// into a staging set and become active together at a frame boundary. If the
// generator is idle, the staged set becomes active on the next clock instead.
//
// Ports
//   clk_in       system clock; all state changes on its rising edge
//   rst_in       asynchronous, active-high reset
//   en           run enable; low holds the counter at 0 and forces outputs low
//   period       frame length in clk_in cycles (staged value)
//   offset_bus   window offsets, window k of channel c at
//                [(c*N_PULSE+k)*WIDTH +: WIDTH]
//   duty_bus     window durations, packed the same way as offset_bus
//   load_req     one-cycle request to stage period/offset_bus/duty_bus
//   load_ack     one-cycle pulse in the first cycle a staged set is active
//   pwm_out      registered channel outputs, bit c = channel c
//   frame_start  registered pulse aligned with the pwm_out sample for cnt = 0
//   cfg_err      high while the active period is below 2
// -----------------------------------------------------------------------------
module pwm_gen_multi #(
    parameter int WIDTH   = 13,
    parameter int N_CH    = 3,
    parameter int N_PULSE = 2
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            en,
    input  logic [WIDTH-1:0]                period,
    input  logic [N_CH*N_PULSE*WIDTH-1:0]   offset_bus,
    input  logic [N_CH*N_PULSE*WIDTH-1:0]   duty_bus,
    input  logic                            load_req,
    output logic                            load_ack,
    output logic [N_CH-1:0]                 pwm_out,
    output logic                            frame_start,
    output logic                            cfg_err
);

    localparam int N_WIN = N_CH * N_PULSE;
    localparam int BUS_W = N_WIN * WIDTH;

    localparam logic [WIDTH-1:0] PERIOD_MIN = WIDTH'(2);
    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] cnt_reg;
    logic [WIDTH-1:0] cnt_next;

    // Active configuration: what the windows are evaluated against.
    logic [WIDTH-1:0] act_period_reg;
    logic [BUS_W-1:0] act_offset_reg;
    logic [BUS_W-1:0] act_duty_reg;

    // Staging configuration: the latest write, waiting for a safe point.
    logic [WIDTH-1:0] stg_period_reg;
    logic [BUS_W-1:0] stg_offset_reg;
    logic [BUS_W-1:0] stg_duty_reg;
    logic             pending_reg;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic             running;
    logic             wrap;
    logic             apply;
    logic [N_WIN-1:0] win_on;
    logic [N_CH-1:0]  pwm_next;

    // A period of 0 or 1 cannot form a frame, so it behaves like en = 0.
    assign running = en && (act_period_reg >= PERIOD_MIN);

    // The >= (rather than ==) keeps the counter inside the frame even if it
    // were ever out of range. The active period only changes at a wrap or
    // while the counter is held at 0, so this is purely defensive.
    assign wrap = running && (cnt_reg >= (act_period_reg - ONE));

    // The staged set becomes active only at a frame boundary while running,
    // or right away while idle. A load_req in the apply cycle writes the new
    // values into staging after the old staged set has been copied to active.
    // That newer set then waits for the following boundary.
    assign apply = pending_reg && (!running || wrap);

    assign cfg_err = (act_period_reg < PERIOD_MIN);

    always_comb begin
        cnt_next = cnt_reg + ONE;
        if (!running || wrap) begin
            cnt_next = '0;
        end
    end

    // ------------------------------------------------------------------
    // Window evaluation. All window arithmetic is WIDTH+1 bits wide, so
    // offset + duration cannot overflow.
    // ------------------------------------------------------------------
    logic [WIDTH:0] per_x;
    logic [WIDTH:0] cnt_x;

    assign per_x = {1'b0, act_period_reg};
    assign cnt_x = {1'b0, cnt_reg};

    genvar gi;
    generate
        for (gi = 0; gi < N_WIN; gi++) begin : g_win
            logic [WIDTH:0] off_x;
            logic [WIDTH:0] dur_x;
            logic [WIDTH:0] end_x;
            logic           in_main;
            logic           in_wrap;

            assign off_x = {1'b0, act_offset_reg[gi*WIDTH +: WIDTH]};
            assign dur_x = {1'b0, act_duty_reg[gi*WIDTH +: WIDTH]};
            assign end_x = off_x + dur_x;

            // Part of the window that lies inside the frame from the offset.
            assign in_main = (cnt_x >= off_x) && (cnt_x < end_x);
            // Part of the window that runs past the frame end and continues
            // at the start of the next frame.
            assign in_wrap = (end_x > per_x) && (cnt_x < (end_x - per_x));

            // Degenerate cases are checked first. A zero duration or an
            // offset outside the frame means off. A duration covering the
            // whole frame means on.
            assign win_on[gi] = (dur_x == '0 || off_x >= per_x) ? 1'b0 :
                                (dur_x >= per_x)                 ? 1'b1 :
                                (in_main || in_wrap);
        end

        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            assign pwm_next[gi] = |win_on[gi*N_PULSE +: N_PULSE];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Frame counter and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt_reg     <= '0;
            pwm_out     <= '0;
            frame_start <= 1'b0;
            load_ack    <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            // The outputs show the window state for the cnt value of the
            // previous cycle, so frame_start lines up with the cnt = 0 sample.
            pwm_out     <= running ? pwm_next : '0;
            frame_start <= running && (cnt_reg == '0);
            load_ack    <= apply;
        end
    end

    // ------------------------------------------------------------------
    // Active configuration
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            act_period_reg <= '0;
            act_offset_reg <= '0;
            act_duty_reg   <= '0;
        end else if (apply) begin
            act_period_reg <= stg_period_reg;
            act_offset_reg <= stg_offset_reg;
            act_duty_reg   <= stg_duty_reg;
        end
    end

    // ------------------------------------------------------------------
    // Staging configuration. The last write before the apply point wins.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            stg_period_reg <= '0;
            stg_offset_reg <= '0;
            stg_duty_reg   <= '0;
            pending_reg    <= 1'b0;
        end else begin
            if (load_req) begin
                stg_period_reg <= period;
                stg_offset_reg <= offset_bus;
                stg_duty_reg   <= duty_bus;
                pending_reg    <= 1'b1;
            end else if (apply) begin
                pending_reg    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_gen_multi.sv
// -----------------------------------------------------------------------------
// tb_pwm_gen_multi
//
// Self-checking bench for pwm_gen_multi. A reference model advances once per
// clock edge. It decides whether each window is on using modular frame
// arithmetic, and it follows the stage/apply rules for the configuration.
// Every output is compared against this model one cycle at a time. Directed
// scenarios also check counts and latencies against fixed expected numbers.
// -----------------------------------------------------------------------------
module tb_pwm_gen_multi;

    localparam int W   = 13;
    localparam int NC  = 3;
    localparam int NP  = 2;
    localparam int BUS = NC * NP * W;

    logic            clk_in;
    logic            rst_in;
    logic            en;
    logic [W-1:0]    period;
    logic [BUS-1:0]  offset_bus;
    logic [BUS-1:0]  duty_bus;
    logic            load_req;
    logic            load_ack;
    logic [NC-1:0]   pwm_out;
    logic            frame_start;
    logic            cfg_err;

    pwm_gen_multi #(.WIDTH(W), .N_CH(NC), .N_PULSE(NP)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .en          (en),
        .period      (period),
        .offset_bus  (offset_bus),
        .duty_bus    (duty_bus),
        .load_req    (load_req),
        .load_ack    (load_ack),
        .pwm_out     (pwm_out),
        .frame_start (frame_start),
        .cfg_err     (cfg_err)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int             m_cnt;
    int             m_p;
    logic [BUS-1:0] m_off;
    logic [BUS-1:0] m_duty;
    int             s_p;
    logic [BUS-1:0] s_off;
    logic [BUS-1:0] s_duty;
    bit             m_pend;
    logic [NC-1:0]  e_pwm;
    logic           e_fs;
    logic           e_ack;
    logic           e_cfg;

    task automatic model_reset();
        m_cnt = 0; m_p = 0; m_off = '0; m_duty = '0;
        s_p = 0; s_off = '0; s_duty = '0; m_pend = 0;
        e_pwm = '0; e_fs = 1'b0; e_ack = 1'b0; e_cfg = 1'b1;
    endtask

    // A window is on when the distance from its offset to cnt, taken
    // modulo the frame length, is shorter than its duration.
    function automatic logic [NC-1:0] model_pwm(int c);
        logic [NC-1:0] r;
        r = '0;
        for (int ch = 0; ch < NC; ch++) begin
            for (int k = 0; k < NP; k++) begin
                int o;
                int d;
                o = int'(m_off[(ch*NP+k)*W +: W]);
                d = int'(m_duty[(ch*NP+k)*W +: W]);
                if (d > 0 && o < m_p && (d >= m_p || ((c - o + m_p) % m_p) < d))
                    r[ch] = 1'b1;
            end
        end
        return r;
    endfunction

    // Advance one clock. The model consumes the inputs present at the edge,
    // and the task returns 1 time unit after the edge so outputs can be sampled.
    task automatic step();
        bit run;
        bit apply;
        @(posedge clk_in);
        if (rst_in) begin
            model_reset();
        end else begin
            run   = en && (m_p >= 2);
            e_pwm = run ? model_pwm(m_cnt) : '0;
            e_fs  = run && (m_cnt == 0);
            apply = m_pend && (!run || m_cnt == m_p - 1);
            e_ack = apply;
            m_cnt = (run && m_cnt != m_p - 1) ? m_cnt + 1 : 0;
            if (apply) begin
                m_p = s_p; m_off = s_off; m_duty = s_duty; m_pend = 0;
            end
            if (load_req) begin
                s_p = int'(period); s_off = offset_bus; s_duty = duty_bus; m_pend = 1;
            end
            e_cfg = (m_p < 2);
        end
        #1;
    endtask

    task automatic clear_cfg();
        offset_bus = '0;
        duty_bus   = '0;
    endtask

    task automatic set_win(int c, int k, int o, int d);
        offset_bus[(c*NP+k)*W +: W] = W'(o);
        duty_bus[(c*NP+k)*W +: W]   = W'(d);
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        step();
        load_req = 1'b0;
    endtask

    task automatic wait_ack(output bit got);
        got = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (load_ack === 1'b1) begin
                got = 1;
                break;
            end
        end
    endtask

    task automatic wait_cnt(input int v, output bit got);
        got = (m_cnt == v);
        for (int i = 0; i < 64 && !got; i++) begin
            step();
            got = (m_cnt == v);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        #1;
        checks++;
        if ({pwm_out, frame_start, load_ack, cfg_err} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_async got %b exp %b", {pwm_out, frame_start, load_ack, cfg_err}, 6'b000001);
        end
        step();
        step();
        rst_in = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            checks++;
            if ({pwm_out, frame_start, load_ack, cfg_err} !== 6'b000001) begin
                errors++;
                $display("FAIL reset_idle cyc %0d got %b exp %b", i, {pwm_out, frame_start, load_ack, cfg_err}, 6'b000001);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_basic();
        int hi0;
        int fs_n;
        clear_cfg();
        period = W'(10);
        set_win(0, 0, 2, 3);
        en = 1'b0;
        pulse_load();
        step();
        checks++;
        if (load_ack !== 1'b1 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle_apply got ack %b cfg %b exp ack 1 cfg 0", load_ack, cfg_err);
        end
        en = 1'b1;
        hi0 = 0;
        fs_n = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            checks++;
            if ({pwm_out, frame_start, load_ack, cfg_err} !== {e_pwm, e_fs, e_ack, e_cfg}) begin
                errors++;
                $display("FAIL basic cyc %0d got %b exp %b", i, {pwm_out, frame_start, load_ack, cfg_err}, {e_pwm, e_fs, e_ack, e_cfg});
            end
            hi0 += int'(pwm_out[0]);
            fs_n += int'(frame_start);
        end
        checks++;
        if (hi0 != 9 || fs_n != 3) begin
            errors++;
            $display("FAIL basic_counts got hi %0d fs %0d exp hi 9 fs 3", hi0, fs_n);
        end
    endtask

    task automatic test_wrap_cases();
        bit got;
        int hi [NC];
        clear_cfg();
        period = W'(10);
        set_win(0, 0, 8, 4);
        set_win(1, 0, 3, 0);
        set_win(2, 0, 5, 12);
        pulse_load();
        wait_ack(got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL wrap_ack_timeout got none exp load_ack");
        end
        for (int c = 0; c < NC; c++) hi[c] = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            checks++;
            if ({pwm_out, frame_start, load_ack, cfg_err} !== {e_pwm, e_fs, e_ack, e_cfg}) begin
                errors++;
                $display("FAIL wrap cyc %0d got %b exp %b", i, {pwm_out, frame_start, load_ack, cfg_err}, {e_pwm, e_fs, e_ack, e_cfg});
            end
            for (int c = 0; c < NC; c++) hi[c] += int'(pwm_out[c]);
        end
        checks++;
        if (hi[0] != 12 || hi[1] != 0 || hi[2] != 30) begin
            errors++;
            $display("FAIL wrap_counts got %0d/%0d/%0d exp 12/0/30", hi[0], hi[1], hi[2]);
        end
    endtask

    task automatic test_or_merge();
        bit got;
        int hi1;
        int rises;
        logic prev;
        clear_cfg();
        period = W'(10);
        set_win(1, 0, 1, 2);
        set_win(1, 1, 6, 2);
        pulse_load();
        wait_ack(got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL or_ack_timeout got none exp load_ack");
        end
        hi1 = 0;
        rises = 0;
        prev = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if ({pwm_out, frame_start, load_ack, cfg_err} !== {e_pwm, e_fs, e_ack, e_cfg}) begin
                errors++;
                $display("FAIL or_merge cyc %0d got %b exp %b", i, {pwm_out, frame_start, load_ack, cfg_err}, {e_pwm, e_fs, e_ack, e_cfg});
            end
            hi1 += int'(pwm_out[1]);
            if (pwm_out[1] === 1'b1 && prev === 1'b0) rises++;
            prev = pwm_out[1];
        end
        checks++;
        if (hi1 != 8 || rises != 4 || pwm_out[0] !== 1'b0) begin
            errors++;
            $display("FAIL or_counts got hi %0d rises %0d exp hi 8 rises 4", hi1, rises);
        end
    endtask

    task automatic test_reload();
        bit got;
        int lat;
        int acks;
        int fs_n;
        // Mid-frame load: the current frame completes first.
        wait_cnt(4, got);
        period = W'(6);
        pulse_load();
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            lat++;
            checks++;
            if ({pwm_out, frame_start, load_ack, cfg_err} !== {e_pwm, e_fs, e_ack, e_cfg}) begin
                errors++;
                $display("FAIL reload_a cyc %0d got %b exp %b", i, {pwm_out, frame_start, load_ack, cfg_err}, {e_pwm, e_fs, e_ack, e_cfg});
            end
            if (load_ack === 1'b1) break;
        end
        checks++;
        if (lat != 5) begin
            errors++;
            $display("FAIL reload_mid_latency got %0d exp 5", lat);
        end
        acks = 0;
        fs_n = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            checks++;
            if ({pwm_out, frame_start, load_ack, cfg_err} !== {e_pwm, e_fs, e_ack, e_cfg}) begin
                errors++;
                $display("FAIL reload_p6 cyc %0d got %b exp %b", i, {pwm_out, frame_start, load_ack, cfg_err}, {e_pwm, e_fs, e_ack, e_cfg});
            end
            acks += int'(load_ack);
            fs_n += int'(frame_start);
        end
        checks++;
        if (acks != 0 || fs_n != 4) begin
            errors++;
            $display("FAIL reload_p6_frames got acks %0d fs %0d exp acks 0 fs 4", acks, fs_n);
        end
        // Restore P = 10, then load exactly on the wrap cycle.
        period = W'(10);
        pulse_load();
        wait_ack(got);
        wait_cnt(9, got);
        set_win(1, 0, 2, 4);
        pulse_load();
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            lat++;
            checks++;
            if ({pwm_out, frame_start, load_ack, cfg_err} !== {e_pwm, e_fs, e_ack, e_cfg}) begin
                errors++;
                $display("FAIL reload_b cyc %0d got %b exp %b", i, {pwm_out, frame_start, load_ack, cfg_err}, {e_pwm, e_fs, e_ack, e_cfg});
            end
            if (load_ack === 1'b1) break;
        end
        checks++;
        if (lat != 10) begin
            errors++;
            $display("FAIL reload_wrap_latency got %0d exp 10", lat);
        end
    endtask

    task automatic test_double_load();
        bit got;
        int hi0;
        int acks;
        clear_cfg();
        period = W'(10);
        wait_cnt(2, got);
        set_win(0, 0, 0, 3);
        pulse_load();
        wait_cnt(5, got);
        set_win(0, 0, 0, 5);
        pulse_load();
        wait_ack(got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL double_ack_timeout got none exp load_ack");
        end
        hi0 = 0;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if ({pwm_out, frame_start, load_ack, cfg_err} !== {e_pwm, e_fs, e_ack, e_cfg}) begin
                errors++;
                $display("FAIL double cyc %0d got %b exp %b", i, {pwm_out, frame_start, load_ack, cfg_err}, {e_pwm, e_fs, e_ack, e_cfg});
            end
            hi0 += int'(pwm_out[0]);
            acks += int'(load_ack);
        end
        checks++;
        if (hi0 != 5 || acks != 0) begin
            errors++;
            $display("FAIL double_result got hi %0d extra_acks %0d exp hi 5 extra_acks 0", hi0, acks);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 8) begin
                period = W'($urandom_range(0, 20));
                for (int c = 0; c < NC; c++)
                    for (int k = 0; k < NP; k++)
                        set_win(c, k, int'($urandom_range(0, 24)), int'($urandom_range(0, 24)));
                load_req = 1'b1;
            end else begin
                load_req = 1'b0;
            end
            if ($urandom_range(0, 99) < 5) en = ~en;
            step();
            checks++;
            if ({pwm_out, frame_start, load_ack, cfg_err} !== {e_pwm, e_fs, e_ack, e_cfg}) begin
                errors++;
                $display("FAIL random cyc %0d got %b exp %b", i, {pwm_out, frame_start, load_ack, cfg_err}, {e_pwm, e_fs, e_ack, e_cfg});
            end
        end
        load_req = 1'b0;
    endtask

    task automatic test_reset_pending();
        bit got;
        int acks;
        int hi;
        en = 1'b1;
        clear_cfg();
        period = W'(10);
        set_win(0, 0, 3, 5);
        pulse_load();
        wait_ack(got);
        wait_cnt(4, got);
        set_win(0, 0, 0, 9);
        pulse_load();
        checks++;
        if ({pwm_out, frame_start, load_ack, cfg_err} !== {e_pwm, e_fs, e_ack, e_cfg} || m_cnt != 5) begin
            errors++;
            $display("FAIL rstpend_pre got %b exp %b", {pwm_out, frame_start, load_ack, cfg_err}, {e_pwm, e_fs, e_ack, e_cfg});
        end
        #2;
        rst_in = 1'b1;
        #1;
        checks++;
        if ({pwm_out, frame_start, load_ack, cfg_err} !== 6'b000001) begin
            errors++;
            $display("FAIL rstpend_async got %b exp %b", {pwm_out, frame_start, load_ack, cfg_err}, 6'b000001);
        end
        step();
        rst_in = 1'b0;
        acks = 0;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if ({pwm_out, frame_start, load_ack, cfg_err} !== {e_pwm, e_fs, e_ack, e_cfg}) begin
                errors++;
                $display("FAIL rstpend_after cyc %0d got %b exp %b", i, {pwm_out, frame_start, load_ack, cfg_err}, {e_pwm, e_fs, e_ack, e_cfg});
            end
            acks += int'(load_ack);
            hi += int'(|pwm_out);
        end
        checks++;
        if (acks != 0 || hi != 0 || cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL rstpend_quiet got acks %0d hi %0d cfg %b exp 0 0 1", acks, hi, cfg_err);
        end
    endtask

    initial begin
        rst_in = 1'b1;
        en = 1'b0;
        period = '0;
        offset_bus = '0;
        duty_bus = '0;
        load_req = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_wrap_cases();
        test_or_merge();
        test_reload();
        test_double_load();
        test_random();
        test_reset_pending();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
